madv_seq: RTL and testbench

- Issue-side sequencer that drives the MAC accelerator's load/execute interface from coprocessor requests.
- Accepts one request at a time (LOAD_INPUT, LOAD_WEIGHT, EXECUTE, CLEAR) from the CV-X-IF decode stage.
- Converts each request into the accelerator's pulse protocol, tracks per-bus element occupancy, waits for the accelerator result, and returns a tagged response.
- Sits between the CV-X-IF issue/result logic and the accelerator instance.

---
 rtl/madv_pkg.sv | 29 ++
 rtl/madv_seq.sv | 219 +++++++++++++++++++++
 tb/tb_madv_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/madv_pkg.sv
// Shared types and constants for the MAC accelerator issue-side sequencer.
package madv_pkg;

  typedef enum logic [1:0] {
    LOAD_INPUT  = 2'd0,
    LOAD_WEIGHT = 2'd1,
    EXECUTE     = 2'd2,
    CLEAR       = 2'd3
  } madv_op_e;

  typedef logic [2:0] madv_state_t;

  localparam madv_state_t StIdle = 3'd0;
  localparam madv_state_t StLoad = 3'd1;
  localparam madv_state_t StGap  = 3'd2;
  localparam madv_state_t StExec = 3'd3;
  localparam madv_state_t StResp = 3'd4;

  localparam int unsigned MADV_MAX_ELEMS = 128;
  localparam int unsigned MADV_ID_WIDTH  = 4;

  typedef struct packed {
    madv_op_e                 op;
    logic [31:0]              data;
    logic [2:0]               count;
    logic [MADV_ID_WIDTH-1:0] id;
  } madv_req_t;

endpackage

// File: rtl/madv_seq.sv
// Turns coprocessor requests into the accelerator load/execute pulse protocol,
// tracks per-bus occupancy and returns one tagged response per request.
module madv_seq
  import madv_pkg::*;
#(
  parameter int unsigned ID_WIDTH  = MADV_ID_WIDTH,
  parameter int unsigned MAX_ELEMS = MADV_MAX_ELEMS,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [1:0]          req_op_i,
  input  logic [31:0]         req_data_i,
  input  logic [2:0]          req_count_i,
  input  logic [ID_WIDTH-1:0] req_id_i,
  output logic                acc_data_valid_o,
  output logic [11:0]         acc_data_count_o,
  output logic [31:0]         acc_data_o,
  output logic                acc_is_input_o,
  output logic                acc_is_weight_o,
  output logic                acc_execute_o,
  input  logic                acc_result_valid_i,
  input  logic [31:0]         acc_result_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [ID_WIDTH-1:0] resp_id_o,
  output logic [31:0]         resp_data_o,
  output logic                resp_err_o
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  madv_state_t     state_q, state_d;
  madv_req_t       req_q, req_d;
  logic [7:0]      cnt_in_q, cnt_in_d;
  logic [7:0]      cnt_wt_q, cnt_wt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            req_ready_q, req_ready_d;
  logic            data_valid_q, data_valid_d;
  logic            is_input_q, is_input_d;
  logic            is_weight_q, is_weight_d;
  logic            execute_q, execute_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [31:0]     resp_data_q, resp_data_d;

  madv_op_e   op_in;
  logic [7:0] cnt_sel;
  logic [8:0] cnt_sum;
  logic       count_ok;
  logic       load_ok;

  assign op_in    = madv_op_e'(req_op_i);
  assign cnt_sel  = (op_in == LOAD_INPUT) ? cnt_in_q : cnt_wt_q;
  // One bit of headroom so a full bus plus a new load cannot wrap past the limit.
  assign cnt_sum  = {1'b0, cnt_sel} + {6'b0, req_count_i};
  assign count_ok = (req_count_i != 3'd0) && (req_count_i <= 3'd4);
  assign load_ok  = count_ok && (cnt_sum <= 9'(MAX_ELEMS));

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cnt_in_d     = cnt_in_q;
    cnt_wt_d     = cnt_wt_q;
    tmo_d        = tmo_q;
    req_ready_d  = req_ready_q;
    data_valid_d = 1'b0;
    is_input_d   = 1'b0;
    is_weight_d  = 1'b0;
    execute_d    = execute_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          req_d.op    = op_in;
          req_d.id    = MADV_ID_WIDTH'(req_id_i);
          req_ready_d = 1'b0;
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          unique case (op_in)
            LOAD_INPUT, LOAD_WEIGHT: begin
              if (load_ok) begin
                // Data/count only move on a real strobe so the bus holds otherwise.
                req_d.data   = req_data_i;
                req_d.count  = req_count_i;
                data_valid_d = 1'b1;
                is_input_d   = (op_in == LOAD_INPUT);
                is_weight_d  = (op_in == LOAD_WEIGHT);
                state_d      = StLoad;
              end else begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                state_d      = StResp;
              end
            end
            EXECUTE: begin
              if ((cnt_in_q == 8'd0) || (cnt_in_q != cnt_wt_q)) begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                state_d      = StResp;
              end else begin
                execute_d = 1'b1;
                tmo_d     = '0;
                state_d   = StExec;
              end
            end
            CLEAR: begin
              cnt_in_d     = '0;
              cnt_wt_d     = '0;
              resp_valid_d = 1'b1;
              state_d      = StResp;
            end
          endcase
        end
      end
      StLoad: begin
        if (req_q.op == LOAD_INPUT) begin
          cnt_in_d = cnt_in_q + {5'b0, req_q.count};
        end else begin
          cnt_wt_d = cnt_wt_q + {5'b0, req_q.count};
        end
        state_d = StGap;
      end
      StGap: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_data_d  = '0;
        state_d      = StResp;
      end
      StExec: begin
        // A result arriving on the timeout cycle still counts as success.
        if (acc_result_valid_i) begin
          execute_d    = 1'b0;
          cnt_in_d     = '0;
          cnt_wt_d     = '0;
          tmo_d        = '0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = acc_result_i;
          state_d      = StResp;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          execute_d    = 1'b0;
          cnt_in_d     = '0;
          cnt_wt_d     = '0;
          tmo_d        = '0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
          state_d      = StResp;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = StIdle;
        end
      end
      default: begin
        execute_d    = 1'b0;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      req_q        <= '0;
      cnt_in_q     <= '0;
      cnt_wt_q     <= '0;
      tmo_q        <= '0;
      req_ready_q  <= 1'b1;
      data_valid_q <= 1'b0;
      is_input_q   <= 1'b0;
      is_weight_q  <= 1'b0;
      execute_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_in_q     <= cnt_in_d;
      cnt_wt_q     <= cnt_wt_d;
      tmo_q        <= tmo_d;
      req_ready_q  <= req_ready_d;
      data_valid_q <= data_valid_d;
      is_input_q   <= is_input_d;
      is_weight_q  <= is_weight_d;
      execute_q    <= execute_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign req_ready_o      = req_ready_q;
  assign acc_data_valid_o = data_valid_q;
  assign acc_data_count_o = {9'b0, req_q.count};
  assign acc_data_o       = req_q.data;
  assign acc_is_input_o   = is_input_q;
  assign acc_is_weight_o  = is_weight_q;
  assign acc_execute_o    = execute_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_id_o        = ID_WIDTH'(req_q.id);
  assign resp_data_o      = resp_data_q;
  assign resp_err_o       = resp_err_q;

endmodule

// File: tb/tb_madv_seq.sv
// Directed self-checking bench for madv_seq: loads, execute, overflow, bad counts,
// timeout, response back-pressure and reset during execute.
module tb_madv_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_data_i;
  logic [2:0]  req_count_i;
  logic [3:0]  req_id_i;
  logic        acc_data_valid_o;
  logic [11:0] acc_data_count_o;
  logic [31:0] acc_data_o;
  logic        acc_is_input_o;
  logic        acc_is_weight_o;
  logic        acc_execute_o;
  logic        acc_result_valid_i;
  logic [31:0] acc_result_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [3:0]  resp_id_o;
  logic [31:0] resp_data_o;
  logic        resp_err_o;

  int checks   = 0;
  int failures = 0;

  int          strobe_cnt  = 0;
  int          exec_cycles = 0;
  logic [31:0] last_data;
  logic [11:0] last_count;
  logic        last_is_in;
  logic        last_is_wt;

  localparam logic [1:0] OpIn = 2'd0, OpWt = 2'd1, OpEx = 2'd2, OpClr = 2'd3;

  madv_seq #(
    .ID_WIDTH (4),
    .MAX_ELEMS(128),
    .TIMEOUT  (16)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_op_i          (req_op_i),
    .req_data_i        (req_data_i),
    .req_count_i       (req_count_i),
    .req_id_i          (req_id_i),
    .acc_data_valid_o  (acc_data_valid_o),
    .acc_data_count_o  (acc_data_count_o),
    .acc_data_o        (acc_data_o),
    .acc_is_input_o    (acc_is_input_o),
    .acc_is_weight_o   (acc_is_weight_o),
    .acc_execute_o     (acc_execute_o),
    .acc_result_valid_i(acc_result_valid_i),
    .acc_result_i      (acc_result_i),
    .resp_valid_o      (resp_valid_o),
    .resp_ready_i      (resp_ready_i),
    .resp_id_o         (resp_id_o),
    .resp_data_o       (resp_data_o),
    .resp_err_o        (resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (acc_data_valid_o) begin
      strobe_cnt <= strobe_cnt + 1;
      last_data  <= acc_data_o;
      last_count <= acc_data_count_o;
      last_is_in <= acc_is_input_o;
      last_is_wt <= acc_is_weight_o;
    end
    if (acc_execute_o) exec_cycles <= exec_cycles + 1;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request and consume its response (resp_ready_i assumed high).
  task automatic do_req(input logic [1:0] op, input logic [31:0] d, input logic [2:0] c,
                        input logic [3:0] id, output logic got, output logic [31:0] rdata,
                        output logic rerr, output logic [3:0] rid);
    int n;
    got = 1'b0; rdata = '0; rerr = 1'b0; rid = '0;
    req_op_i = op; req_data_i = d; req_count_i = c; req_id_i = id; req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 50) begin step(); n++; end
    step();
    req_valid_i = 1'b0;
    n = 0;
    while (!resp_valid_o && n < 60) begin step(); n++; end
    if (resp_valid_o) begin
      got = 1'b1; rdata = resp_data_o; rerr = resp_err_o; rid = resp_id_o;
      step();
    end
  endtask

  // Accelerator stand-in: answers a fixed value a few cycles after execute rises.
  task automatic run_model(input logic [31:0] val, input int delay);
    int n;
    n = 0;
    while (!acc_execute_o && n < 40) begin step(); n++; end
    repeat (delay) step();
    acc_result_i = val;
    acc_result_valid_i = 1'b1;
    step();
    acc_result_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready_o); end
    checks++; if (acc_data_valid_o !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", acc_data_valid_o); end
    checks++; if (acc_execute_o !== 1'b0) begin failures++; $display("FAIL reset_execute got=%b exp=0", acc_execute_o); end
    checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid_o); end
    checks++; if ({resp_data_o, resp_err_o, resp_id_o} !== 37'd0) begin failures++; $display("FAIL reset_resp_fields got=%h exp=0", {resp_data_o, resp_err_o, resp_id_o}); end
    checks++; if ({acc_data_o, acc_data_count_o} !== 44'd0) begin failures++; $display("FAIL reset_acc_bus got=%h exp=0", {acc_data_o, acc_data_count_o}); end
    step();
  endtask

  task automatic test_dot_product();
    logic got, err; logic [31:0] rd; logic [3:0] rid; int s0;
    s0 = strobe_cnt;
    do_req(OpIn, 32'h04030201, 3'd4, 4'h1, got, rd, err, rid);
    checks++; if ({got, err, rid} !== {1'b1, 1'b0, 4'h1}) begin failures++; $display("FAIL load_in_resp got=%b%b%h exp=1 0 1", got, err, rid); end
    checks++; if (strobe_cnt !== s0 + 1) begin failures++; $display("FAIL load_in_strobes got=%0d exp=%0d", strobe_cnt, s0 + 1); end
    checks++; if ({last_is_in, last_is_wt, last_count, last_data} !== {1'b1, 1'b0, 12'd4, 32'h04030201}) begin failures++; $display("FAIL load_in_bus got=%b %b %0d %h exp=1 0 4 04030201", last_is_in, last_is_wt, last_count, last_data); end
    do_req(OpWt, 32'h01010101, 3'd4, 4'h2, got, rd, err, rid);
    checks++; if ({got, err, rid} !== {1'b1, 1'b0, 4'h2}) begin failures++; $display("FAIL load_wt_resp got=%b%b%h exp=1 0 2", got, err, rid); end
    checks++; if (strobe_cnt !== s0 + 2) begin failures++; $display("FAIL load_wt_strobes got=%0d exp=%0d", strobe_cnt, s0 + 2); end
    checks++; if ({last_is_in, last_is_wt, last_count, last_data} !== {1'b0, 1'b1, 12'd4, 32'h01010101}) begin failures++; $display("FAIL load_wt_bus got=%b %b %0d %h exp=0 1 4 01010101", last_is_in, last_is_wt, last_count, last_data); end
    checks++; if (acc_data_o !== 32'h01010101) begin failures++; $display("FAIL data_hold got=%h exp=01010101", acc_data_o); end
    fork
      do_req(OpEx, 32'd0, 3'd1, 4'h3, got, rd, err, rid);
      run_model(32'd10, 2);
    join
    checks++; if ({got, err, rid, rd} !== {1'b1, 1'b0, 4'h3, 32'd10}) begin failures++; $display("FAIL exec_resp got=%b %b %h %0d exp=1 0 3 10", got, err, rid, rd); end
    // Counters are self-cleared, so a second EXECUTE must be refused.
    do_req(OpEx, 32'd0, 3'd1, 4'h4, got, rd, err, rid);
    checks++; if ({got, err} !== 2'b11) begin failures++; $display("FAIL exec_after_clear got=%b%b exp=11", got, err); end
  endtask

  task automatic test_overflow();
    logic got, err; logic [31:0] rd; logic [3:0] rid; int s0; int errs;
    do_req(OpClr, 32'd0, 3'd1, 4'h5, got, rd, err, rid);
    s0 = strobe_cnt; errs = 0;
    for (int i = 0; i < 32; i++) begin
      do_req(OpIn, i, 3'd4, 4'h6, got, rd, err, rid);
      if (!got || err) errs++;
    end
    checks++; if (errs !== 0) begin failures++; $display("FAIL ovf_first32 got=%0d errors exp=0", errs); end
    checks++; if (strobe_cnt !== s0 + 32) begin failures++; $display("FAIL ovf_strobes got=%0d exp=%0d", strobe_cnt, s0 + 32); end
    do_req(OpIn, 32'hFFFF_FFFF, 3'd4, 4'h7, got, rd, err, rid);
    checks++; if ({got, err, rid} !== {1'b1, 1'b1, 4'h7}) begin failures++; $display("FAIL ovf_33rd got=%b%b%h exp=1 1 7", got, err, rid); end
    checks++; if (strobe_cnt !== s0 + 32) begin failures++; $display("FAIL ovf_no_strobe got=%0d exp=%0d", strobe_cnt, s0 + 32); end
    do_req(OpIn, 32'h1, 3'd1, 4'h8, got, rd, err, rid);
    checks++; if ({got, err} !== 2'b11) begin failures++; $display("FAIL ovf_plus1 got=%b%b exp=11", got, err); end
    // Weight bus is independent and still empty.
    do_req(OpWt, 32'h1, 3'd4, 4'h9, got, rd, err, rid);
    checks++; if ({got, err} !== 2'b10) begin failures++; $display("FAIL ovf_wt_ok got=%b%b exp=10", got, err); end
  endtask

  task automatic test_bad_count();
    logic got, err; logic [31:0] rd; logic [3:0] rid; int s0;
    do_req(OpClr, 32'd0, 3'd1, 4'hA, got, rd, err, rid);
    do_req(OpIn, 32'h0A0B0C0D, 3'd4, 4'hA, got, rd, err, rid);
    s0 = strobe_cnt;
    do_req(OpIn, 32'h11111111, 3'd0, 4'hB, got, rd, err, rid);
    checks++; if ({got, err, rid, rd} !== {1'b1, 1'b1, 4'hB, 32'd0}) begin failures++; $display("FAIL cnt0 got=%b %b %h %h exp=1 1 b 0", got, err, rid, rd); end
    do_req(OpWt, 32'h22222222, 3'd5, 4'hC, got, rd, err, rid);
    checks++; if ({got, err, rid} !== {1'b1, 1'b1, 4'hC}) begin failures++; $display("FAIL cnt5 got=%b%b%h exp=1 1 c", got, err, rid); end
    checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL badcnt_no_strobe got=%0d exp=%0d", strobe_cnt, s0); end
    checks++; if (acc_data_o !== 32'h0A0B0C0D) begin failures++; $display("FAIL badcnt_bus_hold got=%h exp=0a0b0c0d", acc_data_o); end
    do_req(OpWt, 32'h01020304, 3'd4, 4'hD, got, rd, err, rid);
    // Execute is only legal if both counters are still exactly 4.
    fork
      do_req(OpEx, 32'd0, 3'd1, 4'hE, got, rd, err, rid);
      run_model(32'h0000_0055, 1);
    join
    checks++; if ({got, err, rd} !== {1'b1, 1'b0, 32'h55}) begin failures++; $display("FAIL badcnt_counters got=%b %b %h exp=1 0 55", got, err, rd); end
  endtask

  task automatic test_timeout();
    logic got, err; logic [31:0] rd; logic [3:0] rid; int e0;
    do_req(OpIn, 32'h0201, 3'd2, 4'h1, got, rd, err, rid);
    do_req(OpWt, 32'h0403, 3'd2, 4'h2, got, rd, err, rid);
    e0 = exec_cycles;
    do_req(OpEx, 32'd0, 3'd1, 4'h3, got, rd, err, rid);
    checks++; if (exec_cycles - e0 !== 16) begin failures++; $display("FAIL timeout_exec_cycles got=%0d exp=16", exec_cycles - e0); end
    checks++; if ({got, err, rid, rd} !== {1'b1, 1'b1, 4'h3, 32'd0}) begin failures++; $display("FAIL timeout_resp got=%b %b %h %h exp=1 1 3 0", got, err, rid, rd); end
    do_req(OpEx, 32'd0, 3'd1, 4'h4, got, rd, err, rid);
    checks++; if ({got, err} !== 2'b11) begin failures++; $display("FAIL timeout_cleared got=%b%b exp=11", got, err); end
  endtask

  task automatic test_back_pressure();
    logic got, err; logic [31:0] rd; logic [3:0] rid; int s0; int n; int bad;
    do_req(OpClr, 32'd0, 3'd1, 4'h0, got, rd, err, rid);
    resp_ready_i = 1'b0;
    req_op_i = OpIn; req_data_i = 32'hAA; req_count_i = 3'd0; req_id_i = 4'h7; req_valid_i = 1'b1;
    step();
    // Queue a legal load behind the stalled response.
    req_op_i = OpIn; req_data_i = 32'hCAFE_F00D; req_count_i = 3'd1; req_id_i = 4'h9;
    s0 = strobe_cnt; bad = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      if ({resp_valid_o, resp_err_o, resp_id_o, resp_data_o, req_ready_o} !== {1'b1, 1'b1, 4'h7, 32'd0, 1'b0}) bad++;
      step();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable got=%0d unstable cycles exp=0", bad); end
    checks++; if (strobe_cnt !== s0) begin failures++; $display("FAIL hold_no_accept got=%0d exp=%0d", strobe_cnt, s0); end
    resp_ready_i = 1'b1;
    step();
    checks++; if ({resp_valid_o, req_ready_o} !== 2'b01) begin failures++; $display("FAIL hold_release got=%b%b exp=01", resp_valid_o, req_ready_o); end
    step();
    req_valid_i = 1'b0;
    checks++; if ({acc_data_valid_o, acc_data_o} !== {1'b1, 32'hCAFE_F00D}) begin failures++; $display("FAIL hold_next_load got=%b %h exp=1 cafef00d", acc_data_valid_o, acc_data_o); end
    n = 0;
    while (!resp_valid_o && n < 20) begin step(); n++; end
    checks++; if ({resp_valid_o, resp_err_o, resp_id_o} !== {1'b1, 1'b0, 4'h9}) begin failures++; $display("FAIL hold_next_resp got=%b%b%h exp=1 0 9", resp_valid_o, resp_err_o, resp_id_o); end
    step();
  endtask

  task automatic test_reset_mid_exec();
    logic got, err; logic [31:0] rd; logic [3:0] rid; int n; int e0;
    do_req(OpClr, 32'd0, 3'd1, 4'h0, got, rd, err, rid);
    do_req(OpIn, 32'h5, 3'd1, 4'h1, got, rd, err, rid);
    do_req(OpWt, 32'h6, 3'd1, 4'h2, got, rd, err, rid);
    req_op_i = OpEx; req_id_i = 4'h3; req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    repeat (3) step();
    checks++; if (acc_execute_o !== 1'b1) begin failures++; $display("FAIL rst_exec_running got=%b exp=1", acc_execute_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if ({acc_execute_o, resp_valid_o, acc_data_valid_o, req_ready_o} !== 4'b0001) begin failures++; $display("FAIL rst_async got=%b exp=0001", {acc_execute_o, resp_valid_o, acc_data_valid_o, req_ready_o}); end
    @(negedge clk_i);
    rst_i = 1'b0;
    e0 = exec_cycles; n = 0;
    repeat (4) begin step(); if (resp_valid_o) n++; end
    checks++; if ({n[3:0], req_ready_o} !== 5'b00001) begin failures++; $display("FAIL rst_no_resp got=%0d resp cycles ready=%b exp=0 1", n, req_ready_o); end
    do_req(OpEx, 32'd0, 3'd1, 4'h4, got, rd, err, rid);
    checks++; if ({got, err, rid} !== {1'b1, 1'b1, 4'h4}) begin failures++; $display("FAIL rst_counters_zero got=%b%b%h exp=1 1 4", got, err, rid); end
    checks++; if (exec_cycles !== e0) begin failures++; $display("FAIL rst_no_exec got=%0d exp=%0d", exec_cycles, e0); end
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_op_i = '0; req_data_i = '0; req_count_i = '0; req_id_i = '0;
    acc_result_valid_i = 1'b0; acc_result_i = '0; resp_ready_i = 1'b1;
    test_reset();
    test_dot_product();
    test_overflow();
    test_bad_count();
    test_timeout();
    test_back_pressure();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
